digit_sum_capture32: RTL
========================

DIGIT_SUM_CAPTURE32 -- requirements
Module: digit_sum_capture32

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops per input rail (legal values 2..4).
REQ-002 SHALL have port clk, input, 1, the single sampling clock.
REQ-003 SHALL have port init_n, input, 1, reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port sum_r1, input, 32, rail-1 of dual-rail sum digit i, driven by the digit-pipelined counter.
REQ-005 SHALL have port sum_r0, input, 32, rail-0 of dual-rail sum digit i.
REQ-006 SHALL have port sum_comp, output, 32, per-digit completion: 1 = DATA consumed, request NULL; 0 = NULL seen, request DATA.
REQ-007 SHALL have port out_valid, output, 1, meaning a captured 32-bit word is held.
REQ-008 SHALL have port out_ready, input, 1, the downstream accept.
REQ-009 SHALL have port out_value, output, 32, the captured word, with bit i taken from digit i.
REQ-010 SHALL have port err_illegal, output, 1, a sticky illegal-code flag (present only with the macro in REQ-026).

Function
REQ-011 SHALL pass every rail through SYNC_STAGES flops before any use; digit encoding: NULL=00, DATA0=01, DATA1=10, illegal=11.
REQ-012 SHALL run an FSM with states COLLECT and FLUSH; the reset state is COLLECT.
REQ-013 In COLLECT, when synchronized digit i is DATA and captured[i]=0, the block SHALL store the bit into shadow[i], set captured[i], and raise sum_comp[i] on the next edge.
REQ-014 Latency from an input digit becoming DATA to sum_comp[i] rising SHALL be exactly SYNC_STAGES+1 clocks.
REQ-015 Digits SHALL be captured independently and in any order; an already-captured digit SHALL ignore further input until FLUSH.
REQ-016 When all 32 digits are captured and the output buffer is free (out_valid=0, or out_valid&out_ready in the same cycle), the block SHALL load shadow into out_value, set out_valid, and enter FLUSH on the same edge.
REQ-017 If all digits are captured but the buffer is occupied, the FSM SHALL stay in COLLECT, sum_comp SHALL stay high, and nothing SHALL be lost.
REQ-018 In FLUSH, when synchronized digit i is NULL, the block SHALL clear captured[i] and drop sum_comp[i] on the next edge; a digit still showing DATA SHALL keep sum_comp[i] high.
REQ-019 When all captured bits are clear, the FSM SHALL return to COLLECT on the next edge; a digit already showing DATA again at that point SHALL be captured starting in the first COLLECT cycle.
REQ-020 out_valid SHALL stay high and out_value SHALL stay stable until a cycle with out_ready=1, after which out_valid SHALL fall unless a new word loads on the same edge.
REQ-021 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-022 On init_n low, the block SHALL asynchronously clear all synchronizer flops, shadow, captured, sum_comp, out_valid, out_value and err_illegal, and SHALL set state to COLLECT.
REQ-023 Reset deassertion SHALL be synchronized internally; the first functional edge SHALL be the second clk edge after init_n rises.
REQ-024 Reset asserted mid-word SHALL discard the partial capture; with sum_comp=0, the upstream SHALL see a request for DATA.

Configuration
REQ-025 The illegal-code check SHALL be selected by macro DIGIT_SUM_ILLEGAL_CHECK_EN.
REQ-026 With DIGIT_SUM_ILLEGAL_CHECK_EN defined, a synchronized 11 on any digit SHALL set err_illegal (sticky until reset), and that digit SHALL be neither captured nor flushed while it reads 11.
REQ-027 Without DIGIT_SUM_ILLEGAL_CHECK_EN, port err_illegal SHALL be absent, and 11 SHALL be treated as DATA1.

Structure
REQ-028 Shared package digit_sum_pkg SHALL hold the dual-rail code constants (NULL, DATA0, DATA1, ILLEGAL), the FSM state typedef, and the digit count constant 32.
REQ-029 The per-digit synchronizer plus capture/flush cell SHALL be one sub-module, digit_capture_cell, instantiated 32 times; the FSM and output buffer SHALL stay at top level.

Verification
REQ-030 Reset check: init_n low with random rails -> sum_comp=0, out_valid=0, out_value=0 immediately and while low.
REQ-031 Single word: all digits NULL, then DATA encoding 0xA5A5_0F0F, SYNC_STAGES=2 -> all sum_comp high 3 clocks later, then out_valid=1 with out_value=0xA5A5_0F0F.
REQ-032 Staggered digits: digit 31 arrives 10 clocks after the rest -> the other sum_comp bits rise early, and out_valid rises only after digit 31 is captured.
REQ-033 Backpressure: out_ready=0 while a second word (0xFFFF_FFFF) completes -> the FSM holds COLLECT with sum_comp all 1; the first word then drains and the second loads on the accept edge.
REQ-034 Flush: after a word is taken, digits return to NULL one per clock -> sum_comp bits fall in the same order, and the FSM returns to COLLECT after the last one.
REQ-035 Illegal code: with the macro defined, digit 5 driven 11 -> err_illegal=1 and digit 5 is not captured; without the macro, digit 5 is captured as 1.

Source files
------------

// File: rtl/digit_sum_pkg.sv
// Shared definitions for the dual-rail sum capture block.
// Latency: none (constants, types and a helper function only).
// Backpressure: not applicable.
package digit_sum_pkg;

    localparam int NUM_DIGITS = 32;

    // Dual-rail codes, written as {rail1, rail0}
    localparam logic [1:0] CODE_NULL    = 2'b00;
    localparam logic [1:0] CODE_DATA0   = 2'b01;
    localparam logic [1:0] CODE_DATA1   = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FLUSH   = 1'b1
    } state_t;

    function automatic logic code_is_null(input logic [1:0] code);
        return code == CODE_NULL;
    endfunction

endpackage

// File: rtl/digit_capture_cell.sv
// One dual-rail digit: rail synchronizers plus the capture/flush handshake bit.
// Latency: input DATA to o_captured high is SYNC_STAGES+1 clocks.
// Backpressure: i_flush gates capture vs. release; the top decides when to flush.
module digit_capture_cell
    import digit_sum_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic init_n,
    input  logic i_run,
    input  logic i_flush,
    input  logic i_r1,
    input  logic i_r0,
    output logic o_captured,
    output logic o_bit
`ifdef DIGIT_SUM_ILLEGAL_CHECK_EN
    ,
    output logic o_illegal
`endif
);

    logic [SYNC_STAGES-1:0] r_sync1;
    logic [SYNC_STAGES-1:0] r_sync0;
    logic                   r_captured;
    logic                   r_shadow;

    logic [1:0] w_code;
    logic       w_is_null;
    logic       w_is_data;

    assign w_code    = {r_sync1[SYNC_STAGES-1], r_sync0[SYNC_STAGES-1]};
    assign w_is_null = code_is_null(w_code);

`ifdef DIGIT_SUM_ILLEGAL_CHECK_EN
    // An 11 digit is neither DATA nor NULL, so it freezes this cell while present
    assign w_is_data = (w_code == CODE_DATA0) || (w_code == CODE_DATA1);
    assign o_illegal = (w_code == CODE_ILLEGAL);
`else
    assign w_is_data = !w_is_null;
`endif

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_sync1 <= '0;
            r_sync0 <= '0;
        end else if (i_run) begin
            r_sync1 <= {r_sync1[SYNC_STAGES-2:0], i_r1};
            r_sync0 <= {r_sync0[SYNC_STAGES-2:0], i_r0};
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_captured <= 1'b0;
            r_shadow   <= 1'b0;
        end else if (i_run) begin
            if (!i_flush && !r_captured && w_is_data) begin
                r_captured <= 1'b1;
                r_shadow   <= w_code[1];
            end else if (i_flush && r_captured && w_is_null) begin
                r_captured <= 1'b0;
            end
        end
    end

    assign o_captured = r_captured;
    assign o_bit      = r_shadow;

endmodule

// File: rtl/digit_sum_capture32.sv
// Captures a 32-digit dual-rail sum into a one-word valid/ready buffer (macro DIGIT_SUM_ILLEGAL_CHECK_EN adds err_illegal).
// Latency: word loads one clock after the last digit completes; digit completion is SYNC_STAGES+1 clocks.
// Backpressure: a full buffer holds COLLECT with sum_comp high, stalling the upstream counter losslessly.
module digit_sum_capture32
    import digit_sum_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  init_n,
    input  logic [NUM_DIGITS-1:0] sum_r1,
    input  logic [NUM_DIGITS-1:0] sum_r0,
    output logic [NUM_DIGITS-1:0] sum_comp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_DIGITS-1:0] out_value
`ifdef DIGIT_SUM_ILLEGAL_CHECK_EN
    ,
    output logic                  err_illegal
`endif
);

    logic                  r_run;
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_load;
    logic                  w_flush;
    logic                  w_all_captured;
    logic                  w_none_captured;
    logic                  w_buf_free;
    logic [NUM_DIGITS-1:0] w_captured;
    logic [NUM_DIGITS-1:0] w_shadow;
    logic                  r_out_valid;
    logic [NUM_DIGITS-1:0] r_out_value;

`ifdef DIGIT_SUM_ILLEGAL_CHECK_EN
    logic [NUM_DIGITS-1:0] w_illegal;
    logic                  r_err_illegal;
`endif

    // Release is seen on the first edge; logic starts working on the second
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_flush = (r_state == ST_FLUSH);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        digit_capture_cell #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cell (
            .clk        (clk),
            .init_n     (init_n),
            .i_run      (r_run),
            .i_flush    (w_flush),
            .i_r1       (sum_r1[gi]),
            .i_r0       (sum_r0[gi]),
            .o_captured (w_captured[gi]),
            .o_bit      (w_shadow[gi])
`ifdef DIGIT_SUM_ILLEGAL_CHECK_EN
            ,
            .o_illegal  (w_illegal[gi])
`endif
        );
    end

    assign w_all_captured  = &w_captured;
    assign w_none_captured = ~|w_captured;
    assign w_buf_free      = !r_out_valid || out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (w_all_captured && w_buf_free) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_none_captured) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state <= ST_COLLECT;
        end else if (r_run) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_out_valid <= 1'b0;
            r_out_value <= '0;
        end else if (r_run) begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_value <= w_shadow;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef DIGIT_SUM_ILLEGAL_CHECK_EN
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_err_illegal <= 1'b0;
        end else if (r_run && (|w_illegal)) begin
            r_err_illegal <= 1'b1;
        end
    end

    assign err_illegal = r_err_illegal;
`endif

    assign sum_comp  = w_captured;
    assign out_valid = r_out_valid;
    assign out_value = r_out_value;

endmodule
